// File: rtl/eth_parser_multi.sv
// -----------------------------------------------------------------------------
// eth_parser_multi
//
// Classifies Ethernet frames from word strobes supplied by the preprocess block
// and searches a table of port MAC addresses, one entry per cycle, to find the
// destination queue. One result per request is pushed into a small
// fall-through FIFO that the consumer pops with eth_parser_rd_info.
//
// Ports
//   clk, reset                 sole clock, synchronous active-high reset
//   in_data                    packet data word
//   word_MAC_DA_HI             in_data carries dst[47:16] in its top 32 bits
//   word_MAC_DASA              in_data[31:16] carries dst[15:0]
//   word_ETH_IP_VER            in_data[31:16] carries the ethertype; starts a search
//   mac_table / mac_en         NUM_MACS x 48-bit port MACs and per-entry enables
//   promisc / accept_mcast     force for-us / accept multicast
//   eth_parser_rd_info         pop the head result
//   eth_parser_info_vld        result FIFO non-empty
//   is_* / mac_dst_port_num    head-of-FIFO result fields (zero while empty)
//   info_overflow              sticky: a result or a search request was lost
// -----------------------------------------------------------------------------
module eth_parser_multi #(
  parameter int unsigned DATA_WIDTH           = 64,
  parameter int unsigned NUM_MACS             = 4,
  parameter int unsigned NUM_QUEUES           = 8,
  parameter int unsigned INFO_FIFO_DEPTH_BITS = 2,
  localparam int unsigned NUM_QUEUES_WIDTH    = $clog2(NUM_QUEUES)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        word_MAC_DA_HI,
  input  logic                        word_MAC_DASA,
  input  logic                        word_ETH_IP_VER,
  input  logic [48*NUM_MACS-1:0]      mac_table,
  input  logic [NUM_MACS-1:0]         mac_en,
  input  logic                        promisc,
  input  logic                        accept_mcast,
  input  logic                        eth_parser_rd_info,
  output logic                        eth_parser_info_vld,
  output logic                        is_for_us,
  output logic                        is_arp_pkt,
  output logic                        is_ip_pkt,
  output logic                        is_vlan,
  output logic                        is_broadcast,
  output logic                        is_multicast,
  output logic [NUM_QUEUES_WIDTH-1:0] mac_dst_port_num,
  output logic                        info_overflow
);

  localparam int unsigned IdxW   = (NUM_MACS > 1) ? $clog2(NUM_MACS) : 1;
  localparam int unsigned Depth  = 1 << INFO_FIFO_DEPTH_BITS;
  localparam int unsigned EntryW = 6 + NUM_QUEUES_WIDTH;
  localparam int unsigned PtrW   = INFO_FIFO_DEPTH_BITS;
  localparam int unsigned CntW   = INFO_FIFO_DEPTH_BITS + 1;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_MACS - 1);

  typedef enum logic [0:0] {StIdle, StSearch} state_e;

  // ---------------------------------------------------------------------------
  // Header capture from the word strobes
  // ---------------------------------------------------------------------------
  logic [47:0] r_dst;
  logic [15:0] r_ethertype;
  logic        r_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_dst       <= '0;
      r_ethertype <= '0;
      r_req       <= 1'b0;
    end else begin
      if (word_MAC_DA_HI) r_dst[47:16] <= in_data[DATA_WIDTH-1:DATA_WIDTH-32];
      if (word_MAC_DASA)  r_dst[15:0]  <= in_data[31:16];
      if (word_ETH_IP_VER) r_ethertype <= in_data[31:16];
      r_req <= word_ETH_IP_VER;
    end
  end

  // Only a few lanes of in_data carry header fields.
  logic w_unused;
  assign w_unused = ^in_data;

  // ---------------------------------------------------------------------------
  // Search FSM
  // ---------------------------------------------------------------------------
  state_e      r_state;
  logic [IdxW-1:0] r_idx;
  logic [47:0] r_s_dst;       // snapshot under search
  logic [15:0] r_s_type;
  logic        r_pend_vld;    // one request may wait while a search runs
  logic [47:0] r_pend_dst;
  logic [15:0] r_pend_type;

  logic [NUM_MACS-1:0] w_hit;
  logic                w_cur_hit;
  logic                w_bcast;
  logic                w_mcast;
  logic                w_done;
  logic                w_req_drop;

  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_MACS; i++) begin
      w_hit[i] = mac_en[i] && (mac_table[48*i +: 48] == r_s_dst);
    end
  end

  assign w_cur_hit  = w_hit[r_idx];
  assign w_bcast    = &r_s_dst;
  assign w_mcast    = r_s_dst[40] && !w_bcast;
  // Broadcast ends the search on its first cycle; it is for us regardless.
  assign w_done     = (r_state == StSearch) && (w_cur_hit || w_bcast || (r_idx == LastIdx));
  assign w_req_drop = r_req && (r_state == StSearch) && r_pend_vld;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_s_dst     <= '0;
      r_s_type    <= '0;
      r_pend_vld  <= 1'b0;
      r_pend_dst  <= '0;
      r_pend_type <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_idx <= '0;
          if (r_pend_vld) begin
            // The held request starts now; a fresh one takes over the slot.
            r_s_dst    <= r_pend_dst;
            r_s_type   <= r_pend_type;
            r_state    <= StSearch;
            r_pend_vld <= r_req;
            if (r_req) begin
              r_pend_dst  <= r_dst;
              r_pend_type <= r_ethertype;
            end
          end else if (r_req) begin
            r_s_dst  <= r_dst;
            r_s_type <= r_ethertype;
            r_state  <= StSearch;
          end
        end
        StSearch: begin
          if (w_done) begin
            r_state <= StIdle;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + IdxW'(1);
          end
          if (r_req && !r_pend_vld) begin
            r_pend_vld  <= 1'b1;
            r_pend_dst  <= r_dst;
            r_pend_type <= r_ethertype;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Result assembly
  // ---------------------------------------------------------------------------
  logic [NUM_QUEUES_WIDTH-1:0] w_port;
  logic                        w_for_us;
  logic [EntryW-1:0]           w_wr_entry;

  assign w_port     = w_cur_hit ? NUM_QUEUES_WIDTH'({r_idx, 1'b0}) : '0;
  assign w_for_us   = w_cur_hit || w_bcast || (w_mcast && accept_mcast) || promisc;
  assign w_wr_entry = {w_for_us,
                       r_s_type == 16'h0806,
                       r_s_type == 16'h0800,
                       r_s_type == 16'h8100,
                       w_bcast,
                       w_mcast,
                       w_port};

  // ---------------------------------------------------------------------------
  // Result FIFO (fall-through)
  // ---------------------------------------------------------------------------
  logic [EntryW-1:0] r_mem [Depth];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [CntW-1:0]   r_count;
  logic              r_overflow;

  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [EntryW-1:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = r_count[CntW-1];
  assign w_pop   = eth_parser_rd_info && !w_empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign w_push  = w_done && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
      if ((w_done && !w_push) || w_req_drop) r_overflow <= 1'b1;
    end
  end

  assign w_head = w_empty ? '0 : r_mem[r_rd_ptr];

  assign eth_parser_info_vld = !w_empty;
  assign is_for_us           = w_head[EntryW-1];
  assign is_arp_pkt          = w_head[EntryW-2];
  assign is_ip_pkt           = w_head[EntryW-3];
  assign is_vlan             = w_head[EntryW-4];
  assign is_broadcast        = w_head[EntryW-5];
  assign is_multicast        = w_head[EntryW-6];
  assign mac_dst_port_num    = w_head[NUM_QUEUES_WIDTH-1:0];
  assign info_overflow       = r_overflow;

endmodule

// File: tb/tb_eth_parser_multi.sv
module tb_eth_parser_multi;

  localparam int unsigned NM = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  in_data;
  logic         word_MAC_DA_HI, word_MAC_DASA, word_ETH_IP_VER;
  logic [191:0] mac_table;
  logic [3:0]   mac_en;
  logic         promisc, accept_mcast, rd_info;
  logic         vld, for_us, arp, ip, vlan, bc, mc, ovf;
  logic [2:0]   port;

  always #5 clk = ~clk;

  eth_parser_multi dut (
    .clk                 (clk),
    .reset               (reset),
    .in_data             (in_data),
    .word_MAC_DA_HI      (word_MAC_DA_HI),
    .word_MAC_DASA       (word_MAC_DASA),
    .word_ETH_IP_VER     (word_ETH_IP_VER),
    .mac_table           (mac_table),
    .mac_en              (mac_en),
    .promisc             (promisc),
    .accept_mcast        (accept_mcast),
    .eth_parser_rd_info  (rd_info),
    .eth_parser_info_vld (vld),
    .is_for_us           (for_us),
    .is_arp_pkt          (arp),
    .is_ip_pkt           (ip),
    .is_vlan             (vlan),
    .is_broadcast        (bc),
    .is_multicast        (mc),
    .mac_dst_port_num    (port),
    .info_overflow       (ovf)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // flags = {for_us, arp, ip, vlan, broadcast, multicast}; due < 0 means untimed
  typedef struct {
    logic [5:0] flags;
    logic [2:0] port;
    int         due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   auto_pop = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [47:0] dst, input logic [15:0] et, input int t);
    exp_t e;
    int   hit = -1;
    int   stop;
    bit   b, m, hm;
    b = (dst == 48'hFFFF_FFFF_FFFF);
    m = dst[40] && !b;
    for (int i = 0; i < NM; i++)
      if (hit < 0 && mac_en[i] && mac_table[48*i +: 48] == dst) hit = i;
    if (b) begin
      stop = 0; hm = (hit == 0);
    end else if (hit >= 0) begin
      stop = hit; hm = 1'b1;
    end else begin
      stop = NM - 1; hm = 1'b0;
    end
    e.port  = hm ? 3'(2 * stop) : 3'd0;
    e.flags = {hm || b || (m && accept_mcast) || promisc,
               et == 16'h0806, et == 16'h0800, et == 16'h8100, b, m};
    e.due   = t + 2 + stop;
    return e;
  endfunction

  // Scoreboard side: compare and pop each head result as it appears.
  always @(negedge clk) begin
    if (auto_pop && vld) begin
      if (sb.size() == 0) begin
        check("spurious_result", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check("flags", {for_us, arp, ip, vlan, bc, mc}, mon_e.flags);
        check("port", port, mon_e.port);
        if (mon_e.due >= 0) check("latency", cyc, mon_e.due);
      end
      rd_info = 1'b1;
    end else begin
      rd_info = 1'b0;
    end
  end

  task automatic load_dst(input logic [47:0] dst);
    @(posedge clk); #1;
    in_data = '0; in_data[63:32] = dst[47:16]; word_MAC_DA_HI = 1'b1;
    @(posedge clk); #1;
    word_MAC_DA_HI = 1'b0;
    in_data = '0; in_data[31:16] = dst[15:0]; word_MAC_DASA = 1'b1;
  endtask

  task automatic send_pkt(input logic [47:0] dst, input logic [15:0] et,
                          input bit store, input bit timed);
    exp_t e;
    load_dst(dst);
    @(posedge clk); #1;
    word_MAC_DASA = 1'b0;
    in_data[31:16] = et; word_ETH_IP_VER = 1'b1;
    e = model(dst, et, cyc + 1);
    if (!timed) e.due = -1;
    if (store) sb.push_back(e);
    @(posedge clk); #1;
    word_ETH_IP_VER = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || vld) && n < budget) begin
      @(posedge clk); n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  localparam logic [47:0] MacE0 = 48'h0200_0000_0010;
  localparam logic [47:0] MacE1 = 48'h0011_2233_4455;
  localparam logic [47:0] MacE2 = 48'h004E_4632_4302;
  localparam logic [47:0] MacE3 = 48'h02AA_BBCC_DDEE;
  localparam logic [47:0] Bcast = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] Mcast = 48'h0100_5E00_0001;
  localparam logic [47:0] Ucast = 48'h0200_0000_9999;

  initial begin
    exp_t e;
    int   t;
    reset = 1'b1; in_data = '0;
    word_MAC_DA_HI = 1'b0; word_MAC_DASA = 1'b0; word_ETH_IP_VER = 1'b0;
    promisc = 1'b0; accept_mcast = 1'b0;
    mac_table = {MacE3, MacE2, MacE1, MacE0};
    mac_en = 4'b1101;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_vld", vld, 0);
    check("rst_flags", {for_us, arp, ip, vlan, bc, mc}, 0);
    check("rst_port", port, 0);
    check("rst_ovf", ovf, 0);

    auto_pop = 1'b1;
    send_pkt(MacE2, 16'h0800, 1, 1); wait_drain(30);   // match at entry 2
    send_pkt(Bcast, 16'h0806, 1, 1); wait_drain(30);   // broadcast ARP
    send_pkt(Mcast, 16'h0800, 1, 1); wait_drain(30);   // multicast rejected
    accept_mcast = 1'b1;
    send_pkt(Mcast, 16'h0800, 1, 1); wait_drain(30);   // multicast accepted
    accept_mcast = 1'b0;
    send_pkt(MacE1, 16'h8100, 1, 1); wait_drain(30);   // disabled entry, VLAN
    promisc = 1'b1;
    send_pkt(MacE1, 16'h8100, 1, 1); wait_drain(30);
    promisc = 1'b0;
    send_pkt(MacE3, 16'h0800, 1, 1); wait_drain(30);   // last entry
    send_pkt(MacE0, 16'h0806, 1, 1); wait_drain(30);   // first entry
    check("ovf_clean", ovf, 0);

    // Three back-to-back requests during one search: one held, third dropped.
    load_dst(Ucast);
    @(posedge clk); #1;
    word_MAC_DASA = 1'b0;
    in_data[31:16] = 16'h0800; word_ETH_IP_VER = 1'b1;
    t = cyc + 1;
    e = model(Ucast, 16'h0800, t);
    sb.push_back(e);
    sb.push_back(model(Ucast, 16'h0806, e.due));
    @(posedge clk); #1;
    in_data[31:16] = 16'h0806;
    @(posedge clk); #1;
    in_data[31:16] = 16'h8100;
    @(posedge clk); #1;
    word_ETH_IP_VER = 1'b0;
    wait_drain(40);
    check("ovf_pending_drop", ovf, 1);
    pulse_reset();
    @(negedge clk);
    check("ovf_after_reset", ovf, 0);

    // Five results with no pops into a 4-deep FIFO.
    auto_pop = 1'b0;
    send_pkt(Bcast, 16'h0800, 1, 0);
    send_pkt(Bcast, 16'h0806, 1, 0);
    send_pkt(Bcast, 16'h8100, 1, 0);
    send_pkt(Bcast, 16'h1234, 1, 0);
    send_pkt(Bcast, 16'h0800, 0, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("full_vld", vld, 1);
    check("ovf_fifo_full", ovf, 1);
    auto_pop = 1'b1;
    wait_drain(30);
    check("ovf_sticky", ovf, 1);
    pulse_reset();
    @(negedge clk);
    check("ovf_cleared", ovf, 0);

    // Reset in the middle of a search must not produce a result.
    send_pkt(Ucast, 16'h0800, 0, 0);
    repeat (2) @(posedge clk);
    #1 pulse_reset();
    repeat (8) @(negedge clk);
    check("abort_vld", vld, 0);
    check("abort_ovf", ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/eth_parser_multi.md
ETH_PARSER_MULTI -- requirements
Module: eth_parser_multi

Interface
REQ-001 Parameter DATA_WIDTH, default 64: input data bus width; SHALL be at least 64.
REQ-002 Parameter NUM_MACS, default 4: number of port MAC entries searched, 1..16.
REQ-003 Parameter NUM_QUEUES, default 8: output queue count; NUM_QUEUES_WIDTH = log2(NUM_QUEUES); 2*NUM_MACS SHALL be at most NUM_QUEUES.
REQ-004 Parameter INFO_FIFO_DEPTH_BITS, default 2: result FIFO depth 2**INFO_FIFO_DEPTH_BITS.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 in_data  in  DATA_WIDTH  packet data word.
REQ-008 word_MAC_DA_HI / word_MAC_DASA / word_ETH_IP_VER  in  1 each  word strobes from preprocess block.
REQ-009 mac_table  in  48*NUM_MACS  entry i at bits [48*i+47:48*i].
REQ-010 mac_en  in  NUM_MACS  per-entry enable; disabled entries never match.
REQ-011 promisc  in  1  forces is_for_us=1.
REQ-012 accept_mcast  in  1  multicast packets are for us.
REQ-013 eth_parser_rd_info  in  1  pop one result.
REQ-014 eth_parser_info_vld  out  1  result FIFO non-empty.
REQ-015 is_for_us, is_arp_pkt, is_ip_pkt, is_vlan, is_broadcast, is_multicast  out  1 each  head-of-FIFO flags.
REQ-016 mac_dst_port_num  out  NUM_QUEUES_WIDTH  2*matched index, 0 if no entry matched.
REQ-017 info_overflow  out  1  sticky: a result or request was lost.

Function
REQ-018 word_MAC_DA_HI SHALL load dst[47:16] from in_data[DATA_WIDTH-1:DATA_WIDTH-32]; word_MAC_DASA SHALL load dst[15:0] from in_data[31:16].
REQ-019 word_ETH_IP_VER at cycle T SHALL latch ethertype=in_data[31:16] and raise search request at T+1.
REQ-020 On request, dst and ethertype SHALL be snapshotted; later strobes SHALL NOT affect an in-progress search.
REQ-021 Classification: broadcast = dst==48'hFFFFFFFFFFFF; multicast = dst[40] and not broadcast; ARP = 0x0806; IP = 0x0800; VLAN = 0x8100 (ARP/IP then 0).
REQ-022 FSM states IDLE, SEARCH. IDLE->SEARCH on request (snapshot pending one, else new), idx=0.
REQ-023 SEARCH compares entry idx per cycle, idx ascending; lowest matching enabled index wins.
REQ-024 SEARCH terminates and writes one result in same cycle on: match, broadcast, or idx==NUM_MACS-1; then ->IDLE; else idx+1.
REQ-025 is_for_us = entry match OR broadcast OR (multicast AND accept_mcast) OR promisc, sampled at write.
REQ-026 Latency: write at T+2 best case, T+1+NUM_MACS worst; eth_parser_info_vld one cycle after write.
REQ-027 One pending request SHALL be held if a request arrives during SEARCH; it starts the cycle after termination.
REQ-028 Request arriving while pending slot full SHALL be dropped and set info_overflow.
REQ-029 Write to full FIFO SHALL be dropped and set info_overflow; simultaneous pop and write when full SHALL succeed.
REQ-030 Pop when empty SHALL be ignored; outputs reflect FIFO head, fall-through.

Reset
REQ-031 Reset SHALL force IDLE, idx=0, pending clear, FIFO empty, info_overflow=0, dst/ethertype=0, eth_parser_info_vld=0, all flags and mac_dst_port_num=0.
REQ-032 Reset mid-search SHALL abort without writing a result.

Verification
REQ-033 NUM_MACS=4, entry2=00:4E:46:32:43:02 enabled, dst equal, ethertype 0x0800 -> for_us=1, ip=1, port=4, write at T+4.
REQ-034 dst FF:FF:FF:FF:FF:FF, ethertype 0x0806 -> broadcast=1, arp=1, for_us=1, port=0, write at T+2.
REQ-035 dst 01:00:5E:00:00:01, accept_mcast=0 then 1 -> multicast=1, for_us 0 then 1, write at T+5.
REQ-036 Entry1 matching but mac_en[1]=0, ethertype 0x8100 -> for_us=0, vlan=1, ip=0; promisc=1 repeat -> for_us=1.
REQ-037 Five results with no pops (depth 4) -> four stored, info_overflow=1 until reset; three back-to-back requests during one search -> third dropped, overflow=1.
